// File: rtl/load_store_unit.sv
// load_store_unit: RISC-V load/store sequencer with lane alignment and sign extension.
// Optional BUSY timeout via `define LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int N       = 32,
  parameter int TIMEOUT = 255
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_write,
  input  logic [2:0]     req_funct3,
  input  logic [N-1:0]   req_addr,
  input  logic [N-1:0]   req_wdata,
  output logic           resp_valid,
  output logic [N-1:0]   resp_rdata,
  output logic [1:0]     resp_err,
  output logic           mem_req,
  output logic           mem_we,
  output logic [N-1:0]   mem_addr,
  output logic [N/8-1:0] mem_be,
  output logic [N-1:0]   mem_wdata,
  input  logic           mem_ack,
  input  logic [N-1:0]   mem_rdata
);
  localparam int B  = N / 8;
  localparam int OW = $clog2(B);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, next;
  logic [OW-1:0] off, off_q;
  logic [1:0]    sz;
  logic [2:0]    f3_q;
  logic [B-1:0]  mask;
  logic [N-1:0]  sh, ext;
  logic          legal, misal, accept, go, tmo;
  assign off    = req_addr[OW-1:0];
  assign sz     = req_funct3[1:0];
  assign accept = req_valid && state == IDLE;
  assign go     = accept && legal && !misal;
  assign legal  = req_write
    ? (req_funct3 inside {3'b000, 3'b001, 3'b010} || (N == 64 && req_funct3 == 3'b011))
    : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101} ||
       (N == 64 && req_funct3 inside {3'b011, 3'b110}));
  assign misal = sz == 2'd1 ? req_addr[0] : sz == 2'd2 ? |req_addr[1:0] :
                 sz == 2'd3 ? |req_addr[2:0] : 1'b0;
  assign mask  = sz == 2'd0 ? B'(8'h01) : sz == 2'd1 ? B'(8'h03) :
                 sz == 2'd2 ? B'(8'h0F) : B'(8'hFF);
`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clock)
    cnt <= (reset || state != BUSY) ? '0 : cnt + CW'(1);
  assign tmo = cnt == CW'(TIMEOUT - 1);
`else
  localparam int unused_timeout = TIMEOUT;
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clock)
    state <= reset ? IDLE : next;
  always_comb
    next = state == IDLE ? (req_valid ? ((!legal || misal) ? RESP : BUSY) : IDLE) :
           state == BUSY ? ((mem_ack || tmo) ? RESP : BUSY) : IDLE;
  always_comb begin
    req_ready  = state == IDLE;
    mem_req    = state == BUSY;
    resp_valid = state == RESP;
  end
  // Load data is realigned to bit 0 using the offset captured at accept.
  assign sh = mem_rdata >> {off_q, 3'b000};
  always_comb
    ext = f3_q == 3'b000 ? N'($signed(sh[7:0]))  :
          f3_q == 3'b001 ? N'($signed(sh[15:0])) :
          f3_q == 3'b010 ? N'($signed(sh[31:0])) :
          f3_q == 3'b100 ? N'(sh[7:0])           :
          f3_q == 3'b101 ? N'(sh[15:0])          :
          f3_q == 3'b110 ? N'(sh[31:0])          : sh;
  always_ff @(posedge clock)
    if (reset) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      resp_err   <= 2'b00;
      resp_rdata <= '0;
      f3_q       <= '0;
      off_q      <= '0;
    end else begin
      if (go) begin
        mem_we    <= req_write;
        mem_addr  <= req_addr & ~N'(B - 1);
        mem_be    <= mask << off;
        mem_wdata <= req_wdata << {off, 3'b000};
        f3_q      <= req_funct3;
        off_q     <= off;
      end
      if (accept && !go) begin
        resp_err   <= legal ? 2'b01 : 2'b10;
        resp_rdata <= '0;
      end
      if (state == BUSY && mem_ack) begin
        resp_err   <= 2'b00;
        resp_rdata <= mem_we ? '0 : ext;
      end else if (state == BUSY && tmo) begin
        resp_err   <= 2'b11;
        resp_rdata <= '0;
      end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit (N=32 and N=64 instances).
module tb_load_store_unit;
  logic        clock = 1'b0, reset = 1'b1;
  logic        req_valid = 0, req_write = 0, mem_ack = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
  logic        req_ready, resp_valid, mem_req, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [1:0]  resp_err;
  logic [3:0]  mem_be;
  logic        d_req_valid = 0, d_mem_ack = 0;
  logic [2:0]  d_req_funct3 = 0;
  logic [63:0] d_req_addr = 0, d_mem_rdata = 0;
  logic        d_req_ready, d_resp_valid, d_mem_req, d_mem_we;
  logic [63:0] d_resp_rdata, d_mem_addr, d_mem_wdata;
  logic [1:0]  d_resp_err;
  logic [7:0]  d_mem_be;
  int checks = 0, errors = 0;

  load_store_unit #(.N(32), .TIMEOUT(4)) u (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  load_store_unit #(.N(64), .TIMEOUT(4)) u64 (
    .clock(clock), .reset(reset), .req_valid(d_req_valid), .req_ready(d_req_ready),
    .req_write(1'b0), .req_funct3(d_req_funct3), .req_addr(d_req_addr),
    .req_wdata(64'd0), .resp_valid(d_resp_valid), .resp_rdata(d_resp_rdata),
    .resp_err(d_resp_err), .mem_req(d_mem_req), .mem_we(d_mem_we), .mem_addr(d_mem_addr),
    .mem_be(d_mem_be), .mem_wdata(d_mem_wdata), .mem_ack(d_mem_ack), .mem_rdata(d_mem_rdata)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1; req_write = w; req_funct3 = f; req_addr = a; req_wdata = d;
    @(negedge clock);
    req_valid = 0;
  endtask

  task automatic ack(input logic [31:0] rd);
    mem_ack = 1; mem_rdata = rd;
    @(negedge clock);
    mem_ack = 0;
  endtask

  task automatic load(input string tag, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] rd, input logic [3:0] be, input logic [31:0] exp);
    send(0, f, a, 0);
    chk({tag, "_be"}, mem_be, be);
    chk({tag, "_req"}, mem_req, 1);
    ack(rd);
    chk({tag, "_rv"}, resp_valid, 1);
    chk({tag, "_data"}, resp_rdata, exp);
    chk({tag, "_err"}, resp_err, 0);
    @(negedge clock);
  endtask

  task automatic bad(input string tag, input logic w, input logic [2:0] f,
                     input logic [31:0] a, input logic [1:0] err);
    send(w, f, a, 32'hFFFF_FFFF);
    chk({tag, "_rv"}, resp_valid, 1);
    chk({tag, "_err"}, resp_err, err);
    chk({tag, "_req"}, mem_req, 0);
    @(negedge clock);
    chk({tag, "_rv_off"}, resp_valid, 0);
  endtask

  initial begin
    @(negedge clock);
    chk("rst_rv", resp_valid, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_rdata", resp_rdata, 0);
    reset = 0;
    @(negedge clock);
    chk("rst_ready", req_ready, 1);

    send(0, 3'b000, 32'h103, 0);
    chk("lb_ready", req_ready, 0);
    chk("lb_req", mem_req, 1);
    chk("lb_we", mem_we, 0);
    chk("lb_addr", mem_addr, 32'h100);
    chk("lb_be", mem_be, 4'b1000);
    ack(32'h80FF_1234);
    chk("lb_rv", resp_valid, 1);
    chk("lb_data", resp_rdata, 32'hFFFF_FF80);
    chk("lb_err", resp_err, 0);
    chk("lb_req_drop", mem_req, 0);
    @(negedge clock);
    chk("lb_rv_off", resp_valid, 0);
    chk("lb_ready2", req_ready, 1);
    chk("lb_hold", resp_rdata, 32'hFFFF_FF80);

    send(1, 3'b001, 32'h202, 32'hAAAA_BEEF);
    chk("sh_addr", mem_addr, 32'h200);
    chk("sh_be", mem_be, 4'b1100);
    chk("sh_wd", mem_wdata[31:16], 16'hBEEF);
    chk("sh_we", mem_we, 1);
    ack(32'h1234_5678);
    chk("sh_rv", resp_valid, 1);
    chk("sh_data", resp_rdata, 0);
    chk("sh_err", resp_err, 0);
    @(negedge clock);

    send(1, 3'b000, 32'h301, 32'h0000_0055);
    chk("sb_be", mem_be, 4'b0010);
    chk("sb_wd", mem_wdata[15:8], 8'h55);
    ack(0);
    @(negedge clock);

    load("lh", 3'b001, 32'h102, 32'h80FF_1234, 4'b1100, 32'hFFFF_80FF);
    load("lhu", 3'b101, 32'h102, 32'h80FF_1234, 4'b1100, 32'h0000_80FF);
    load("lbu", 3'b100, 32'h101, 32'h80FF_1234, 4'b0010, 32'h0000_0012);
    load("lw", 3'b010, 32'h40, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

    bad("mis_lw", 0, 3'b010, 32'h006, 2'b01);
    bad("mis_sh", 1, 3'b001, 32'h003, 2'b01);
    bad("ill_ld", 0, 3'b011, 32'h008, 2'b10);
    bad("ill_pri", 0, 3'b011, 32'h001, 2'b10);
    bad("ill_sd", 1, 3'b011, 32'h000, 2'b10);
    bad("ill_lwu", 0, 3'b110, 32'h000, 2'b10);

    mem_ack = 1;
    @(negedge clock);
    mem_ack = 0;
    chk("stray_ack_rv", resp_valid, 0);
    chk("stray_ack_ready", req_ready, 1);

    send(0, 3'b010, 32'h10, 0);
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      chk("to_wait_req", mem_req, 1);
      @(negedge clock);
    end
    chk("to_last_req", mem_req, 1);
    @(negedge clock);
    chk("to_rv", resp_valid, 1);
    chk("to_err", resp_err, 2'b11);
    chk("to_req_drop", mem_req, 0);
    @(negedge clock);
    send(0, 3'b010, 32'h10, 0);
    for (int i = 0; i < 3; i++) @(negedge clock);
    ack(32'h0BAD_F00D);
    chk("to_ack_rv", resp_valid, 1);
    chk("to_ack_err", resp_err, 0);
    chk("to_ack_data", resp_rdata, 32'h0BAD_F00D);
`else
    for (int i = 0; i < 10; i++) begin
      chk("wait_rv", resp_valid, 0);
      chk("wait_req", mem_req, 1);
      @(negedge clock);
    end
    ack(32'h0BAD_F00D);
    chk("wait_ack_rv", resp_valid, 1);
    chk("wait_ack_data", resp_rdata, 32'h0BAD_F00D);
`endif
    @(negedge clock);

    send(0, 3'b010, 32'h20, 0);
    chk("mid_busy", mem_req, 1);
    reset = 1;
    @(negedge clock);
    reset = 0;
    chk("mid_req", mem_req, 0);
    chk("mid_rv", resp_valid, 0);
    @(negedge clock);
    chk("mid_ready", req_ready, 1);
    chk("mid_rv2", resp_valid, 0);

    d_req_valid = 1; d_req_funct3 = 3'b011; d_req_addr = 64'h8;
    @(negedge clock);
    d_req_valid = 0;
    chk("ld_be", d_mem_be, 8'hFF);
    chk("ld_addr", d_mem_addr, 64'h8);
    d_mem_ack = 1; d_mem_rdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clock);
    d_mem_ack = 0;
    chk("ld_rv", d_resp_valid, 1);
    chk("ld_data", d_resp_rdata, 64'h0123_4567_89AB_CDEF);
    chk("ld_err", d_resp_err, 0);
    @(negedge clock);
    d_req_valid = 1; d_req_funct3 = 3'b010; d_req_addr = 64'h4;
    @(negedge clock);
    d_req_valid = 0;
    chk("lw64_be", d_mem_be, 8'hF0);
    d_mem_ack = 1; d_mem_rdata = 64'h8000_0000_1111_1111;
    @(negedge clock);
    d_mem_ack = 0;
    chk("lw64_data", d_resp_rdata, 64'hFFFF_FFFF_8000_0000);
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter N, default 32, data/address width in bits; legal values 32 and 64.
REQ-002 Parameter TIMEOUT, default 255, maximum BUSY cycles spent waiting for mem_ack.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  CPU request present.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RISC-V funct3 size/sign code.
REQ-009 req_addr  input  N  byte address.
REQ-010 req_wdata  input  N  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  N  extended load data; 0 for stores and errors.
REQ-013 resp_err  output  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout.
REQ-014 mem_req  output  1  registered memory request, held until acknowledged.
REQ-015 mem_we  output  1  memory write enable.
REQ-016 mem_addr  output  N  req_addr with the low log2(N/8) bits cleared.
REQ-017 mem_be  output  N/8  byte enables.
REQ-018 mem_wdata  output  N  lane-shifted store data.
REQ-019 mem_ack  input  1  memory completion; sampled only in BUSY.
REQ-020 mem_rdata  input  N  full-width read data, valid with mem_ack.

Function
REQ-021 The FSM SHALL have three states: IDLE, BUSY and RESP; req_ready SHALL be 1 only in IDLE.
REQ-022 A request SHALL be accepted when req_valid=1 and req_ready=1; all request fields are captured in that cycle.
REQ-023 Legal loads SHALL be funct3 000 lb, 001 lh, 010 lw, 100 lbu and 101 hu; 011 ld and 110 lwu SHALL be legal only when N=64.
REQ-024 Legal stores SHALL be funct3 000, 001 and 010; 011 SHALL be legal only when N=64.
REQ-025 Any other funct3 SHALL take IDLE->RESP with resp_err=10, and mem_req SHALL never assert.
REQ-026 A misaligned access SHALL take IDLE->RESP with resp_err=01 and no memory access: half needs addr[0]=0, word needs addr[1:0]=0, double needs addr[2:0]=0.
REQ-027 Illegal funct3 SHALL take priority over misalignment.
REQ-028 A legal, aligned request SHALL take IDLE->BUSY; mem_req=1 from the next cycle, with mem_we, mem_addr, mem_be and mem_wdata stable until the ack.
REQ-029 Byte enables: mem_be = size mask (1, 3, 0xF or 0xFF) shifted left by off, where off = addr[log2(N/8)-1:0].
REQ-030 mem_wdata SHALL be req_wdata shifted left by 8*off; unused lanes are don't-care.
REQ-031 In BUSY, mem_ack=1 SHALL move the FSM to RESP and drop mem_req in the following cycle.
REQ-032 Load data SHALL be mem_rdata shifted right by 8*off, then sign- or zero-extended per funct3.
REQ-033 In RESP, resp_valid SHALL be 1 for exactly one cycle, then the FSM returns to IDLE; there is no response backpressure.
REQ-034 Minimum latency: accept at t, mem_req at t+1, ack at t+1, resp_valid at t+2; an error response SHALL appear at t+1.
REQ-035 mem_ack outside BUSY SHALL be ignored.
REQ-036 resp_rdata and resp_err SHALL hold their values until the next resp_valid.

Reset
REQ-037 With reset high at a clock edge, the state SHALL go to IDLE, and resp_valid, mem_req, mem_we, mem_be, resp_err, resp_rdata, mem_addr and mem_wdata SHALL become 0.
REQ-038 A reset in BUSY or RESP SHALL drop the transaction with no response; req_ready=1 in the cycle after reset deasserts.

Configuration
REQ-039 Macro LSU_TIMEOUT_EN SHALL enable a BUSY-cycle counter, cleared on entry to BUSY.
REQ-040 With LSU_TIMEOUT_EN, after TIMEOUT consecutive BUSY cycles without ack, the FSM SHALL go to RESP with resp_err=11 and drop mem_req; an ack in the terminal cycle wins and returns ok.
REQ-041 Without LSU_TIMEOUT_EN, there SHALL be no counter logic, and BUSY waits indefinitely.

Verification
REQ-042 Load, N=32: lb at addr 0x103 with mem_rdata=0x80FF_1234 -> mem_be=1000, resp_rdata=0xFFFF_FF80, err=00.
REQ-043 Store: sh at addr 0x202, wdata=0xAAAA_BEEF -> mem_addr=0x200, mem_be=1100, mem_wdata[31:16]=0xBEEF, mem_we=1.
REQ-044 Misaligned: lw at addr 0x006 -> resp_valid one cycle after accept, err=01, mem_req stays 0.
REQ-045 Illegal funct3: load funct3=011 with N=32 -> err=10; with N=64, ld at 0x8 returns the full 64-bit mem_rdata.
REQ-046 Timeout, macro defined, TIMEOUT=4: mem_ack held 0 -> err=11 after 4 BUSY cycles; an ack on cycle 4 -> err=00.
REQ-047 Reset mid-operation: reset pulsed in BUSY -> no resp_valid, mem_req=0 next cycle, req_ready=1 after release.
